pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/rat_pkg.sv | 35 +++
 rtl/int_ctrl.sv | 110 +++++++++++
 rtl/pc_unit.sv | 100 ++++++++++
 tb/tb_pc_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared definitions for the RAT program-counter slice: widths, vectors, select and state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   PC_WIDTH      default program counter width
//   RESET_VECTOR  default PC value after reset
//   INT_VECTOR    default interrupt service entry address
//   pc_mux_sel_t  PC load source select
//   int_state_t   interrupt controller state
package rat_pkg;

   localparam int                    PC_WIDTH     = 10;
   localparam logic [PC_WIDTH-1:0]   RESET_VECTOR = 10'h000;
   localparam logic [PC_WIDTH-1:0]   INT_VECTOR   = 10'h3FF;

   // PC load source. SEL_HOLD reloads the current PC, so a load with it is a no-op.
   typedef enum logic [1:0] {
      SEL_IMMED  = 2'd0,
      SEL_STACK  = 2'd1,
      SEL_INTVEC = 2'd2,
      SEL_HOLD   = 2'd3
   } pc_mux_sel_t;

   // Interrupt controller state.
   //   ST_DIS  : interrupts disabled, requests discarded
   //   ST_EN   : interrupts enabled, waiting for a request edge
   //   ST_PEND : request latched, waiting for the control unit to acknowledge
   typedef enum logic [1:0] {
      ST_DIS  = 2'd0,
      ST_EN   = 2'd1,
      ST_PEND = 2'd2
   } int_state_t;

endpackage

// File: rtl/int_ctrl.sv
// Interrupt request synchronizer, edge detector and enable/pending state machine.
// Latency: INT rising before edge k raises INT_PENDING after edge k+2; control inputs act after one edge.
// Backpressure: none; a request stays pending until INT_ACK or I_CLR, requests while disabled are dropped.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-high reset (hard and soft reset already merged by the parent)
//   INT          external interrupt request, asynchronous level
//   I_SET        enable interrupts
//   I_CLR        disable interrupts (wins over I_SET and over a simultaneous request)
//   INT_ACK      control unit entering the interrupt cycle
//   INT_PENDING  registered request to the control unit
//   IE           registered interrupt-enable flag
module int_ctrl (
   input  logic CLK,
   input  logic RESET,
   input  logic INT,
   input  logic I_SET,
   input  logic I_CLR,
   input  logic INT_ACK,
   output logic INT_PENDING,
   output logic IE
);

   import rat_pkg::*;

   // Two-flop synchronizer followed by a history flop for edge detection.
   logic int_meta;
   logic int_sync;
   logic int_hist;
   logic int_event;

   int_state_t state_q;
   int_state_t state_d;

   logic ie_q;
   logic pend_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         int_meta <= 1'b0;
         int_sync <= 1'b0;
         int_hist <= 1'b0;
      end else begin
         int_meta <= INT;
         int_sync <= int_meta;
         int_hist <= int_sync;
      end
   end

   // A request is a rising edge of the synchronized level. Holding INT high
   // produces exactly one event, so re-enabling with INT still high does not
   // fire a request until INT drops and rises again.
   assign int_event = int_sync & ~int_hist;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_DIS;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_DIS: begin
            // I_SET together with I_CLR behaves as I_CLR, i.e. stays disabled.
            // Events seen here are dropped, never queued.
            if (I_SET && !I_CLR) begin
               state_d = ST_EN;
            end
         end
         ST_EN: begin
            // Disable beats a request arriving in the same cycle.
            if (I_CLR) begin
               state_d = ST_DIS;
            end else if (int_event) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            // Acknowledge disables further interrupts until software re-enables.
            // I_SET alone leaves the request pending.
            if (I_CLR || INT_ACK) begin
               state_d = ST_DIS;
            end
         end
         default: begin
            state_d = ST_DIS;
         end
      endcase
   end

   // Outputs are registered copies of the next-state decode so they change
   // on the same edge as the state and carry no combinational path to the pins.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ie_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         ie_q   <= (state_d == ST_EN) || (state_d == ST_PEND);
         pend_q <= (state_d == ST_PEND);
      end
   end

   assign IE          = ie_q;
   assign INT_PENDING = pend_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with load mux, modulo increment and interrupt controller.
// Latency: control asserted in cycle n is visible on PC_COUNT after the next rising edge.
// Backpressure: none; PC_LD wins over PC_INC, reset (RESET or RST) wins over everything.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-high hard reset
//   RST          control-unit soft reset, same effect as RESET
//   PC_LD        load PC from the mux
//   PC_INC       increment PC (ignored when PC_LD is set)
//   PC_MUX_SEL   0 FROM_IMMED, 1 FROM_STACK, 2 INT_VECTOR, 3 current PC
//   FROM_IMMED   branch/call target
//   FROM_STACK   return address
//   INT          external interrupt request, asynchronous level
//   I_SET        enable interrupts
//   I_CLR        disable interrupts
//   INT_ACK      control unit entering the interrupt cycle
//   PC_COUNT     registered PC, program ROM address
//   INT_PENDING  registered interrupt request
//   IE           interrupt-enable flag
module pc_unit #(
   parameter int                  PC_WIDTH     = rat_pkg::PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = rat_pkg::RESET_VECTOR,
   parameter logic [PC_WIDTH-1:0] INT_VECTOR   = rat_pkg::INT_VECTOR
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                RST,
   input  logic                PC_LD,
   input  logic                PC_INC,
   input  logic [1:0]          PC_MUX_SEL,
   input  logic [PC_WIDTH-1:0] FROM_IMMED,
   input  logic [PC_WIDTH-1:0] FROM_STACK,
   input  logic                INT,
   input  logic                I_SET,
   input  logic                I_CLR,
   input  logic                INT_ACK,
   output logic [PC_WIDTH-1:0] PC_COUNT,
   output logic                INT_PENDING,
   output logic                IE
);

   import rat_pkg::*;

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   // Hard and soft reset are indistinguishable inside this block.
   logic any_rst;
   assign any_rst = RESET | RST;

   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] mux_dat;
   logic [PC_WIDTH-1:0] pc_d;
   pc_mux_sel_t         mux_sel;

   assign mux_sel = pc_mux_sel_t'(PC_MUX_SEL);

   always_comb begin
      mux_dat = pc_q;
      case (mux_sel)
         SEL_IMMED:  mux_dat = FROM_IMMED;
         SEL_STACK:  mux_dat = FROM_STACK;
         SEL_INTVEC: mux_dat = INT_VECTOR;
         SEL_HOLD:   mux_dat = pc_q;
         default:    mux_dat = pc_q;
      endcase
   end

   // Load beats increment; the increment wraps silently at the top of the space.
   always_comb begin
      pc_d = pc_q;
      if (PC_LD) begin
         pc_d = mux_dat;
      end else if (PC_INC) begin
         pc_d = pc_q + PC_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (any_rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign PC_COUNT = pc_q;

   int_ctrl u_int_ctrl (
      .CLK         (CLK),
      .RESET       (any_rst),
      .INT         (INT),
      .I_SET       (I_SET),
      .I_CLR       (I_CLR),
      .INT_ACK     (INT_ACK),
      .INT_PENDING (INT_PENDING),
      .IE          (IE)
   );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: scoreboard + falling-edge monitor, plus inline spot checks.
// Latency: expectations sampled one edge after stimulus is applied.
// Backpressure: n/a; stimulus is free-running, drain of the scoreboard is bounded.
module tb_pc_unit;

    logic       CLK;
    logic       RESET;
    logic       RST;
    logic       PC_LD;
    logic       PC_INC;
    logic [1:0] PC_MUX_SEL;
    logic [9:0] FROM_IMMED;
    logic [9:0] FROM_STACK;
    logic       INT;
    logic       I_SET;
    logic       I_CLR;
    logic       INT_ACK;
    logic [9:0] PC_COUNT;
    logic       INT_PENDING;
    logic       IE;

    pc_unit #(
        .PC_WIDTH     (10),
        .RESET_VECTOR (10'h000),
        .INT_VECTOR   (10'h3FF)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .RST         (RST),
        .PC_LD       (PC_LD),
        .PC_INC      (PC_INC),
        .PC_MUX_SEL  (PC_MUX_SEL),
        .FROM_IMMED  (FROM_IMMED),
        .FROM_STACK  (FROM_STACK),
        .INT         (INT),
        .I_SET       (I_SET),
        .I_CLR       (I_CLR),
        .INT_ACK     (INT_ACK),
        .PC_COUNT    (PC_COUNT),
        .INT_PENDING (INT_PENDING),
        .IE          (IE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         due;
        logic [9:0] pc;
        logic       pend;
        logic       ie;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (mon_e.due != cyc || PC_COUNT !== mon_e.pc ||
                INT_PENDING !== mon_e.pend || IE !== mon_e.ie) begin
                n_fail++;
                $display("FAIL %s: got pc=%h pend=%b ie=%b, want pc=%h pend=%b ie=%b (cycle %0d, due %0d)",
                         mon_e.name, PC_COUNT, INT_PENDING, IE,
                         mon_e.pc, mon_e.pend, mon_e.ie, cyc, mon_e.due);
            end
        end
    end

    task automatic step(input string nm, input logic [9:0] pc, input logic pend, input logic ie);
        exp_t e;
        e.name = nm;
        e.due  = cyc + 1;
        e.pc   = pc;
        e.pend = pend;
        e.ie   = ie;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_ctl();
        RESET = 0; RST = 0; PC_LD = 0; PC_INC = 0; PC_MUX_SEL = 2'd0;
        I_SET = 0; I_CLR = 0; INT_ACK = 0;
    endtask

    initial begin
        idle_ctl();
        RESET = 1; INT = 0;
        FROM_IMMED = 10'h000; FROM_STACK = 10'h000;

        step("reset_a", 10'h000, 0, 0);
        step("reset_b", 10'h000, 0, 0);
        RESET = 0;

        PC_INC = 1;
        step("inc1", 10'h001, 0, 0);
        step("inc2", 10'h002, 0, 0);
        step("inc3", 10'h003, 0, 0);
        n_checks++;
        if (PC_COUNT !== 10'h003) begin
            n_fail++;
            $display("FAIL spot_inc3: got pc=%h want 003", PC_COUNT);
        end
        PC_INC = 0;
        step("hold", 10'h003, 0, 0);

        PC_LD = 1; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h3FF;
        step("load_3ff", 10'h3FF, 0, 0);
        PC_LD = 0; PC_INC = 1;
        step("wrap", 10'h000, 0, 0);
        n_checks++;
        if (PC_COUNT !== 10'h000) begin
            n_fail++;
            $display("FAIL spot_wrap: got pc=%h want 000", PC_COUNT);
        end

        PC_LD = 1; PC_INC = 1; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h155; FROM_STACK = 10'h2A0;
        step("ld_immed", 10'h155, 0, 0);
        PC_MUX_SEL = 2'd1;
        step("ld_stack", 10'h2A0, 0, 0);
        n_checks++;
        if (PC_COUNT !== 10'h2A0) begin
            n_fail++;
            $display("FAIL spot_ld_stack: got pc=%h want 2a0", PC_COUNT);
        end
        PC_MUX_SEL = 2'd3;
        step("ld_hold", 10'h2A0, 0, 0);
        idle_ctl();

        I_SET = 1;
        step("sei", 10'h2A0, 0, 1);
        I_SET = 0; INT = 1;
        step("int_e1", 10'h2A0, 0, 1);
        step("int_e2", 10'h2A0, 0, 1);
        step("int_e3", 10'h2A0, 1, 1);
        n_checks++;
        if (INT_PENDING !== 1'b1) begin
            n_fail++;
            $display("FAIL spot_int_e3: got pend=%b want 1", INT_PENDING);
        end
        step("pend_hold", 10'h2A0, 1, 1);
        INT_ACK = 1; PC_LD = 1; PC_MUX_SEL = 2'd2;
        step("ack_vec", 10'h3FF, 0, 0);
        n_checks++;
        if (PC_COUNT !== 10'h3FF || IE !== 1'b0) begin
            n_fail++;
            $display("FAIL spot_ack_vec: got pc=%h ie=%b want pc=3ff ie=0", PC_COUNT, IE);
        end
        idle_ctl();

        INT = 0;
        step("dis_low1", 10'h3FF, 0, 0);
        step("dis_low2", 10'h3FF, 0, 0);
        step("dis_low3", 10'h3FF, 0, 0);
        INT = 1;
        step("dis_pulse", 10'h3FF, 0, 0);
        INT = 0;
        for (int i = 0; i < 3; i++) step("dis_drop", 10'h3FF, 0, 0);

        INT = 1;
        for (int i = 0; i < 3; i++) step("dis_high", 10'h3FF, 0, 0);
        I_SET = 1;
        step("sei_high", 10'h3FF, 0, 1);
        I_SET = 0;
        for (int i = 0; i < 3; i++) step("en_high_nopend", 10'h3FF, 0, 1);
        INT_ACK = 1;
        step("ack_in_en", 10'h3FF, 0, 1);
        INT_ACK = 0;
        INT = 0;
        for (int i = 0; i < 3; i++) step("en_low", 10'h3FF, 0, 1);
        INT = 1;
        step("re_e1", 10'h3FF, 0, 1);
        step("re_e2", 10'h3FF, 0, 1);
        step("re_e3", 10'h3FF, 1, 1);

        I_SET = 1;
        step("sei_in_pend", 10'h3FF, 1, 1);
        I_CLR = 1;
        step("set_clr_pend", 10'h3FF, 0, 0);
        I_CLR = 0;
        step("sei_again", 10'h3FF, 0, 1);
        I_SET = 0;

        INT = 0;
        for (int i = 0; i < 3; i++) step("en_low2", 10'h3FF, 0, 1);
        INT = 1;
        step("clr_e1", 10'h3FF, 0, 1);
        step("clr_e2", 10'h3FF, 0, 1);
        I_CLR = 1;
        step("clr_vs_event", 10'h3FF, 0, 0);
        I_CLR = 0;
        step("clr_no_pend", 10'h3FF, 0, 0);

        PC_LD = 1; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h123;
        step("ld_123", 10'h123, 0, 0);
        PC_LD = 0; I_SET = 1;
        step("sei_123", 10'h123, 0, 1);
        I_SET = 0; INT = 0;
        for (int i = 0; i < 3; i++) step("low_123", 10'h123, 0, 1);
        INT = 1;
        step("p_e1", 10'h123, 0, 1);
        step("p_e2", 10'h123, 0, 1);
        step("p_e3", 10'h123, 1, 1);
        RST = 1; PC_LD = 1; PC_INC = 1; PC_MUX_SEL = 2'd0; FROM_IMMED = 10'h155; I_SET = 1;
        step("rst_in_pend", 10'h000, 0, 0);
        n_checks++;
        if (PC_COUNT !== 10'h000 || IE !== 1'b0 || INT_PENDING !== 1'b0) begin
            n_fail++;
            $display("FAIL spot_rst_in_pend: got pc=%h pend=%b ie=%b want 000/0/0",
                     PC_COUNT, INT_PENDING, IE);
        end
        idle_ctl();
        for (int i = 0; i < 3; i++) step("post_rst", 10'h000, 0, 0);

        PC_INC = 1;
        step("inc_a", 10'h001, 0, 0);
        RESET = 1; PC_LD = 1; FROM_IMMED = 10'h2AA;
        step("hard_rst_ld", 10'h000, 0, 0);
        idle_ctl();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, want pc=%h pend=%b ie=%b", mon_e.name, mon_e.pc, mon_e.pend, mon_e.ie);
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
